// File: rtl/pulse_transmitter_sequencer.sv
// Plays a programmed pulse train on pulse_out: each table symbol is a level held for
// duration+1 cycles, and the whole program can repeat loop_count extra times.
module pulse_transmitter_sequencer #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DURATION_WIDTH = 8,
    parameter int LOOP_WIDTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [ADDR_WIDTH-1:0]   program_last,
    input  logic [LOOP_WIDTH-1:0]   loop_count,
    input  logic                    idle_level,
    output logic [ADDR_WIDTH-1:0]   symbol_addr,
    input  logic [DURATION_WIDTH:0] symbol_data,
    output logic                    pulse_out,
    output logic                    busy,
    output logic                    symbol_strobe,
    output logic                    done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q, state_d;
    logic                      start_q;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]     last_q, last_d;
    logic [DURATION_WIDTH-1:0] cnt_q, cnt_d;
    logic [LOOP_WIDTH-1:0]     loops_q, loops_d;
    logic                      pulse_q, pulse_d;
    logic                      busy_q, busy_d;
    logic                      strobe_q, strobe_d;
    logic                      done_q, done_d;
    logic                      final_q, final_d;

    logic                      startEdge;
    logic                      doLoad;
    logic [ADDR_WIDTH-1:0]     loadLast;
    logic [LOOP_WIDTH-1:0]     loadLoops;

    assign startEdge = start & ~start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            addr_q   <= '0;
            last_q   <= '0;
            cnt_q    <= '0;
            loops_q  <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            final_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            addr_q   <= addr_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            loops_q  <= loops_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            final_q  <= final_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        loops_d   = loops_q;
        pulse_d   = pulse_q;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        final_d   = final_q;
        doLoad    = 1'b0;
        loadLast  = last_q;
        loadLoops = loops_q;

        case (state_q)
            IDLE: begin
                pulse_d = idle_level;
                addr_d  = '0;
                busy_d  = 1'b0;
                // The launch load must see the fresh config, not the still-stale latches.
                if (startEdge && !stop) begin
                    last_d    = program_last;
                    loops_d   = loop_count;
                    loadLast  = program_last;
                    loadLoops = loop_count;
                    doLoad    = 1'b1;
                    state_d   = RUN;
                    busy_d    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    pulse_d = idle_level;
                    addr_d  = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (final_q) begin
                    state_d = IDLE;
                    pulse_d = idle_level;
                    addr_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    doLoad = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // final_d marks the last symbol of the last pass so completion needs no extra lookahead.
        if (doLoad) begin
            pulse_d  = symbol_data[DURATION_WIDTH];
            cnt_d    = symbol_data[DURATION_WIDTH-1:0];
            strobe_d = 1'b1;
            if (addr_q == loadLast) begin
                addr_d  = '0;
                final_d = (loadLoops == '0);
                if (loadLoops != '0) begin
                    loops_d = loadLoops - 1'b1;
                end
            end else begin
                addr_d  = addr_q + 1'b1;
                final_d = 1'b0;
            end
        end
    end

    assign symbol_addr   = addr_q;
    assign pulse_out     = pulse_q;
    assign busy          = busy_q;
    assign symbol_strobe = strobe_q;
    assign done          = done_q;

endmodule

// File: tb/tb_pulse_transmitter_sequencer.sv
// Self-checking bench for pulse_transmitter_sequencer; expected waveforms come from a
// per-symbol expansion of the program table kept in a queue.
module tb_pulse_transmitter_sequencer;
    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic       stop;
    logic [2:0] programLast;
    logic [7:0] loopCount;
    logic       idleLevel;
    logic [2:0] symbolAddr;
    logic [8:0] symbolData;
    logic       pulseOut;
    logic       busy;
    logic       symbolStrobe;
    logic       done;

    logic [8:0] tableMem [8];
    logic [6:0] expQ [$];
    logic [6:0] obs;
    int         errorCount = 0;
    int         checkCount = 0;

    always #5 clk = ~clk;

    assign symbolData = tableMem[symbolAddr];

    pulse_transmitter_sequencer #(
        .ADDR_WIDTH(3), .DURATION_WIDTH(8), .LOOP_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rstN), .start(start), .stop(stop),
        .program_last(programLast), .loop_count(loopCount), .idle_level(idleLevel),
        .symbol_addr(symbolAddr), .symbol_data(symbolData), .pulse_out(pulseOut),
        .busy(busy), .symbol_strobe(symbolStrobe), .done(done)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] observe();
        return {pulseOut, busy, symbolStrobe, done, symbolAddr};
    endfunction

    // Expected per-cycle {pulse, busy, strobe, done, addr} for a whole run, starting with the launch edge.
    task automatic build_expected(input int last, input int loops, input logic idle);
        int dur;
        expQ.delete();
        for (int p = 0; p <= loops; p++) begin
            for (int i = 0; i <= last; i++) begin
                dur = int'(tableMem[i][7:0]);
                for (int c = 0; c <= dur; c++) begin
                    expQ.push_back({tableMem[i][8], 1'b1, (c == 0), 1'b0,
                                    (i == last) ? 3'd0 : 3'(i + 1)});
                end
            end
        end
        expQ.push_back({idle, 1'b0, 1'b0, 1'b1, 3'd0});
        expQ.push_back({idle, 1'b0, 1'b0, 1'b0, 3'd0});
    endtask

    task automatic load_basic_table();
        for (int i = 0; i < 8; i++) tableMem[i] = 9'h000;
        tableMem[0] = 9'h103;
        tableMem[1] = 9'h001;
        tableMem[2] = 9'h100;
    endtask

    task automatic applyStimulus(input int last, input int loops, input logic idle);
        programLast = 3'(last);
        loopCount   = 8'(loops);
        idleLevel   = idle;
        start       = 1'b0;
        stop        = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL %s: timeout, busy=%b required 0", name, busy);
        end
        checkCount++;
        tick();
    endtask

    task automatic test_reset();
        rstN = 1'b0; start = 1'b0; stop = 1'b0; idleLevel = 1'b1;
        programLast = 3'd0; loopCount = 8'd0;
        load_basic_table();
        #2;
        obs = observe();
        checkCount++;
        if (obs !== 7'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_values: got %b required %b", obs, 7'b0);
        end
        #10 rstN = 1'b1;
        tick();
        obs = observe();
        checkCount++;
        if (obs !== 7'b1000000) begin
            errorCount++;
            $display("[TB] FAIL idle_follow_high: got %b required %b", obs, 7'b1000000);
        end
        idleLevel = 1'b0;
        tick();
        obs = observe();
        checkCount++;
        if (obs !== 7'b0) begin
            errorCount++;
            $display("[TB] FAIL idle_follow_low: got %b required %b", obs, 7'b0);
        end
    endtask

    task automatic test_basic();
        load_basic_table();
        applyStimulus(2, 0, 1'b0);
        build_expected(2, 0, 1'b0);
        start = 1'b1;
        foreach (expQ[k]) begin
            tick();
            if (k == 0) start = 1'b0;
            obs = observe();
            checkCount++;
            if (obs !== expQ[k]) begin
                errorCount++;
                $display("[TB] FAIL basic cycle %0d: got %b required %b", k, obs, expQ[k]);
            end
        end
    endtask

    task automatic test_repeat();
        load_basic_table();
        applyStimulus(2, 2, 1'b0);
        build_expected(2, 2, 1'b0);
        start = 1'b1;
        foreach (expQ[k]) begin
            tick();
            if (k == 0) start = 1'b0;
            obs = observe();
            checkCount++;
            if (obs !== expQ[k]) begin
                errorCount++;
                $display("[TB] FAIL repeat cycle %0d: got %b required %b", k, obs, expQ[k]);
            end
        end
    endtask

    task automatic test_held_start();
        load_basic_table();
        applyStimulus(2, 0, 1'b0);
        build_expected(2, 0, 1'b0);
        start = 1'b1;
        foreach (expQ[k]) begin
            tick();
            if (k == 2) start = 1'b0;
            if (k == 3) start = 1'b1;
            obs = observe();
            checkCount++;
            if (obs !== expQ[k]) begin
                errorCount++;
                $display("[TB] FAIL held_run cycle %0d: got %b required %b", k, obs, expQ[k]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checkCount++;
            if (busy !== 1'b0 || symbolStrobe !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL held_no_relaunch: busy=%b strobe=%b required 0 0", busy, symbolStrobe);
            end
        end
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        checkCount++;
        if (busy !== 1'b1 || symbolStrobe !== 1'b1 || pulseOut !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL held_relaunch: busy=%b strobe=%b pulse=%b required 1 1 1",
                     busy, symbolStrobe, pulseOut);
        end
        start = 1'b0;
        wait_idle(50, "held_relaunch_end");
    endtask

    task automatic test_stop();
        load_basic_table();
        applyStimulus(2, 0, 1'b1);
        start = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            tick();
            if (k == 0) start = 1'b0;
        end
        obs = observe();
        checkCount++;
        if (obs !== 7'b0110010) begin
            errorCount++;
            $display("[TB] FAIL stop_pre_symbol1: got %b required %b", obs, 7'b0110010);
        end
        stop = 1'b1;
        tick();
        obs = observe();
        checkCount++;
        if (obs !== 7'b1000000) begin
            errorCount++;
            $display("[TB] FAIL stop_abort: got %b required %b", obs, 7'b1000000);
        end
        stop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkCount++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL stop_no_done: done=%b busy=%b required 0 0", done, busy);
            end
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || symbolStrobe !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL stop_beats_start: busy=%b strobe=%b required 0 0", busy, symbolStrobe);
        end
        tick();
        checkCount++;
        if (busy !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL stop_no_late_launch: busy=%b required 0", busy);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_config_sampling();
        load_basic_table();
        applyStimulus(2, 0, 1'b0);
        build_expected(2, 0, 1'b0);
        start = 1'b1;
        foreach (expQ[k]) begin
            tick();
            if (k == 0) start = 1'b0;
            if (k == 1) begin
                programLast = 3'd0;
                loopCount   = 8'd5;
            end
            obs = observe();
            checkCount++;
            if (obs !== expQ[k]) begin
                errorCount++;
                $display("[TB] FAIL config_sampling cycle %0d: got %b required %b", k, obs, expQ[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        load_basic_table();
        applyStimulus(2, 0, 1'b1);
        start = 1'b1;
        tick();
        tick();
        #3 rstN = 1'b0;
        #1;
        obs = observe();
        checkCount++;
        if (obs !== 7'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_async: got %b required %b", obs, 7'b0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = observe();
            checkCount++;
            if (obs !== 7'b0) begin
                errorCount++;
                $display("[TB] FAIL reset_hold: got %b required %b", obs, 7'b0);
            end
        end
        #3 rstN = 1'b1;
        build_expected(2, 0, 1'b1);
        foreach (expQ[k]) begin
            tick();
            if (k == 0) start = 1'b0;
            obs = observe();
            checkCount++;
            if (obs !== expQ[k]) begin
                errorCount++;
                $display("[TB] FAIL reset_relaunch cycle %0d: got %b required %b", k, obs, expQ[k]);
            end
        end
    endtask

    task automatic test_random();
        int last;
        int loops;
        logic idle;
        for (int it = 0; it < 7; it++) begin
            if (it < 6) begin
                for (int i = 0; i < 8; i++) begin
                    tableMem[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 4))};
                end
                last  = int'($urandom_range(0, 7));
                loops = int'($urandom_range(0, 3));
                idle  = 1'($urandom_range(0, 1));
            end else begin
                tableMem[0] = 9'h100;
                last  = 0;
                loops = 255;
                idle  = 1'b0;
            end
            applyStimulus(last, loops, idle);
            build_expected(last, loops, idle);
            start = 1'b1;
            foreach (expQ[k]) begin
                tick();
                if (k == 0) start = 1'b0;
                obs = observe();
                checkCount++;
                if (obs !== expQ[k]) begin
                    errorCount++;
                    $display("[TB] FAIL random%0d cycle %0d: got %b required %b", it, k, obs, expQ[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_held_start();
        test_stop();
        test_config_sampling();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
